// File: rtl/anton_neopixel_registers_mc.sv
// anton_neopixel_registers_mc
// Bus-facing register file and per-channel pixel buffers for a multi-channel
// NeoPixel streamer. Each channel owns a byte buffer (bus read/write port
// plus a registered streamer read port), a max-index register, control bits
// and a sticky overflow flag. A single shared FSM clears one channel buffer at
// a time when software requests an init on that channel.
module anton_neopixel_registers_mc #(
    parameter int CHANNELS   = 2,
    parameter int BUFFER_END = 255
) (
    input  logic                   busClk,
    input  logic                   busReset,
    input  logic [13:0]            busAddr,
    input  logic [7:0]             busDataIn,
    input  logic                   busWrite,
    input  logic                   busRead,
    output logic [7:0]             busDataOut,
    input  logic [CHANNELS-1:0]    streamSyncOf,
    input  logic [CHANNELS-1:0]    syncStart,
    input  logic [CHANNELS-1:0]    state,
    input  logic [CHANNELS*10-1:0] pixAddr,
    output logic [CHANNELS*8-1:0]  pixData,
    output logic [CHANNELS*10-1:0] regMax,
    output logic [CHANNELS-1:0]    regCtrlLimit,
    output logic [CHANNELS-1:0]    regCtrlRun,
    output logic [CHANNELS-1:0]    regCtrlLoop,
    output logic [CHANNELS-1:0]    regCtrl32bit,
    output logic [CHANNELS-1:0]    initBusy,
    output logic [CHANNELS-1:0]    initDone
);

    localparam int DEPTH       = BUFFER_END + 1;
    localparam int BUFFER_BITS = $clog2(DEPTH);

    localparam logic [BUFFER_BITS-1:0] IDX_LAST = BUFFER_BITS'(BUFFER_END);

    // Register offsets inside a channel's register window
    localparam logic [2:0] REG_MAX_LO = 3'd0;
    localparam logic [2:0] REG_MAX_HI = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;
    localparam logic [2:0] REG_OVF    = 3'd4;

    // Clear FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic                   is_reg;
    logic [2:0]             buf_ch;
    logic [9:0]             buf_idx;
    logic [BUFFER_BITS-1:0] buf_idx_m;
    logic                   buf_idx_ok;
    logic [2:0]             reg_ch;
    logic [2:0]             reg_sel;

    assign is_reg     = busAddr[13];
    assign buf_ch     = busAddr[12:10];
    assign buf_idx    = busAddr[9:0];
    assign buf_idx_m  = buf_idx[BUFFER_BITS-1:0];
    assign buf_idx_ok = int'(buf_idx) <= BUFFER_END;
    assign reg_ch     = busAddr[5:3];
    assign reg_sel    = busAddr[2:0];

    // ------------------------------------------------------------------
    // Per-channel state
    // ------------------------------------------------------------------
    logic [CHANNELS*10-1:0] reg_max_q;
    logic [CHANNELS-1:0]    limit_q;
    logic [CHANNELS-1:0]    run_q;
    logic [CHANNELS-1:0]    loop_q;
    logic [CHANNELS-1:0]    b32_q;
    logic [CHANNELS-1:0]    ovf_q;
    // The ctrl.init bit and the clear-pending bit are set and cleared on the
    // same edges, so one flop serves as both (and as initBusy).
    logic [CHANNELS-1:0]    pending_q;

    // Clear FSM state
    logic [1:0]             clr_state;
    logic [2:0]             clr_ch;
    logic [BUFFER_BITS-1:0] clr_idx;
    logic [2:0]             pick_ch;

    // Per-channel decoded strobes
    logic [CHANNELS-1:0]    buf_sel;
    logic [CHANNELS-1:0]    reg_hit;
    logic [CHANNELS-1:0]    ctrl_wr;
    logic [CHANNELS-1:0]    ovf_clr;
    logic [CHANNELS-1:0]    clr_active;

    logic [CHANNELS*8-1:0]  bus_rd_ch;
    logic [7:0]             rd_data;

    // Decode bus access into per-channel select and write strobes
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        buf_sel    = '0;
        reg_hit    = '0;
        ctrl_wr    = '0;
        ovf_clr    = '0;
        clr_active = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            // Buffer access is blocked while the channel is busy clearing.
            buf_sel[c]    = !is_reg && buf_idx_ok && (int'(buf_ch) == c) && !pending_q[c];
            reg_hit[c]    = busWrite && is_reg && (int'(reg_ch) == c);
            // A busy channel ignores every ctrl write, including a repeated init.
            ctrl_wr[c]    = reg_hit[c] && (reg_sel == REG_CTRL) && !pending_q[c];
            ovf_clr[c]    = reg_hit[c] && (reg_sel == REG_OVF) && busDataIn[0];
            clr_active[c] = (clr_state == ST_CLEAR) && (int'(clr_ch) == c);
        end
    end

    // ------------------------------------------------------------------
    // Pixel buffers, one memory per channel
    // ------------------------------------------------------------------
    for (genvar g = 0; g < CHANNELS; g++) begin : gen_ch
        logic [7:0] mem [DEPTH];
        logic [9:0] pix_idx;
        logic [7:0] pix_q;

        assign pix_idx = pixAddr[g*10 +: 10];

        // Buffer write port: the clear FSM or the bus, never both for one channel
        // NOTE: the buffer has no reset; its contents are undefined until
        // written or cleared, which keeps it mappable to block RAM.
        always_ff @(posedge busClk) begin
            if (clr_active[g]) begin
                mem[clr_idx] <= 8'd0;
            end else if (busWrite && buf_sel[g]) begin
                mem[buf_idx_m] <= busDataIn;
            end
        end

        // Streamer read port, one cycle latency, zero when out of range
        always_ff @(posedge busClk) begin
            if (int'(pix_idx) <= BUFFER_END) begin
                pix_q <= mem[pix_idx[BUFFER_BITS-1:0]];
            end else begin
                pix_q <= 8'd0;
            end
        end

        assign pixData[g*8 +: 8]   = pix_q;
        assign bus_rd_ch[g*8 +: 8] = mem[buf_idx_m];
    end

    // ------------------------------------------------------------------
    // Bus read mux
    // ------------------------------------------------------------------
    // Select read data from the register window or the buffer region
    always_comb begin
        rd_data = 8'd0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (is_reg && (int'(reg_ch) == c)) begin
                case (reg_sel)
                    REG_MAX_LO: rd_data = reg_max_q[c*10 +: 8];
                    REG_MAX_HI: rd_data = {6'd0, reg_max_q[c*10+8 +: 2]};
                    REG_CTRL:   rd_data = {3'd0, b32_q[c], loop_q[c], run_q[c],
                                           limit_q[c], pending_q[c]};
                    REG_STATUS: rd_data = {6'd0, pending_q[c], state[c]};
                    REG_OVF:    rd_data = {7'd0, ovf_q[c]};
                    default:    rd_data = 8'd0;
                endcase
            end else if (buf_sel[c]) begin
                rd_data = bus_rd_ch[c*8 +: 8];
            end
        end
    end

    // Registered read data: loads on a read strobe, holds otherwise
    always_ff @(posedge busClk or posedge busReset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (busReset) begin
            busDataOut <= 8'd0;
        end else if (busRead) begin
            busDataOut <= rd_data;
        end
    end

    // ------------------------------------------------------------------
    // Control, max, overflow and clear-pending registers
    // ------------------------------------------------------------------
    // Per-channel register updates with stream events taking priority over the bus
    always_ff @(posedge busClk or posedge busReset) begin
        if (busReset) begin
            reg_max_q <= '0;
            limit_q   <= '0;
            run_q     <= '0;
            loop_q    <= '0;
            b32_q     <= '0;
            ovf_q     <= '0;
            pending_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (reg_hit[c] && (reg_sel == REG_MAX_LO)) begin
                    reg_max_q[c*10 +: 8] <= busDataIn;
                end
                if (reg_hit[c] && (reg_sel == REG_MAX_HI)) begin
                    reg_max_q[c*10+8 +: 2] <= busDataIn[1:0];
                end

                // An init write zeroes the other control bits on the same edge.
                if (ctrl_wr[c]) begin
                    limit_q[c] <= busDataIn[1] & ~busDataIn[0];
                    loop_q[c]  <= busDataIn[3] & ~busDataIn[0];
                    b32_q[c]   <= busDataIn[4] & ~busDataIn[0];
                end

                // run: start pulse, then end-of-frame reload from loop, then bus.
                if (syncStart[c]) begin
                    run_q[c] <= 1'b1;
                end else if (streamSyncOf[c]) begin
                    run_q[c] <= loop_q[c];
                end else if (ctrl_wr[c]) begin
                    run_q[c] <= busDataIn[2] & ~busDataIn[0];
                end

                // Frame end while stopped is an overflow; setting wins over clearing.
                if (streamSyncOf[c] && !run_q[c]) begin
                    ovf_q[c] <= 1'b1;
                end else if (ovf_clr[c]) begin
                    ovf_q[c] <= 1'b0;
                end

                if (ctrl_wr[c] && busDataIn[0]) begin
                    pending_q[c] <= 1'b1;
                end else if ((clr_state == ST_DONE) && (int'(clr_ch) == c)) begin
                    pending_q[c] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Shared clear FSM
    // ------------------------------------------------------------------
    // Pick the lowest-numbered channel with a clear pending
    always_comb begin
        pick_ch = 3'd0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (pending_q[c]) begin
                pick_ch = 3'(c);
            end
        end
    end

    // Walk the selected buffer from index 0 to the last index, then pulse done
    always_ff @(posedge busClk or posedge busReset) begin
        if (busReset) begin
            clr_state <= ST_IDLE;
            clr_ch    <= 3'd0;
            clr_idx   <= '0;
        end else begin
            case (clr_state)
                ST_IDLE: begin
                    if (|pending_q) begin
                        clr_state <= ST_CLEAR;
                        clr_ch    <= pick_ch;
                        clr_idx   <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_idx == IDX_LAST) begin
                        clr_state <= ST_DONE;
                    end else begin
                        clr_idx <= clr_idx + BUFFER_BITS'(1);
                    end
                end
                ST_DONE: begin
                    clr_state <= ST_IDLE;
                end
                default: begin
                    clr_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Done pulse for the active channel, decoded from the registered state
    always_comb begin
        initDone = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            initDone[c] = (clr_state == ST_DONE) && (int'(clr_ch) == c);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign regMax       = reg_max_q;
    assign regCtrlLimit = limit_q;
    assign regCtrlRun   = run_q;
    assign regCtrlLoop  = loop_q;
    assign regCtrl32bit = b32_q;
    assign initBusy     = pending_q;

endmodule

// File: doc/anton_neopixel_registers_mc.md
ANTON_NEOPIXEL_REGISTERS_MC -- requirements
Module: anton_neopixel_registers_mc

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of independent pixel channels (1..8).
REQ-002 SHALL have parameter BUFFER_END, default 255, last pixel byte index per channel (1..1023); BUFFER_BITS = CLOG2(BUFFER_END+1).
REQ-003 SHALL have one clock and an asynchronous, active-high reset; ports follow in REQ-004..REQ-019.
REQ-004 busClk  in  1  sole clock, all state on rising edge.
REQ-005 busReset  in  1  asynchronous, active-high reset.
REQ-006 busAddr  in  14  [13]=0 buffer region, [12:10] channel, [9:0] pixel index; [13]=1 register region, [5:3] channel, [2:0] register.
REQ-007 busDataIn  in  8  write data.
REQ-008 busWrite  in  1  write strobe, one access per cycle.
REQ-009 busRead  in  1  read strobe.
REQ-010 busDataOut  out  8  registered read data.
REQ-011 streamSyncOf  in  CHANNELS  per-channel end-of-frame pulse.
REQ-012 syncStart  in  CHANNELS  per-channel start pulse.
REQ-013 state  in  CHANNELS  per-channel streamer state bit, read-only status.
REQ-014 pixAddr  in  CHANNELS*10  per-channel streamer read index.
REQ-015 pixData  out  CHANNELS*8  per-channel streamer read data.
REQ-016 regMax  out  CHANNELS*10  per-channel max pixel index.
REQ-017 regCtrlLimit, regCtrlRun, regCtrlLoop, regCtrl32bit  out  CHANNELS each  per-channel control bits.
REQ-018 initBusy  out  CHANNELS  channel is being cleared or has clear pending.
REQ-019 initDone  out  CHANNELS  one-cycle pulse when channel clear completes.

Function
REQ-020 Register map per channel SHALL be: 0 max[7:0] RW; 1 {6'b0,max[9:8]} RW; 2 {3'b0,32bit,loop,run,limit,init} RW; 3 {6'b0,initBusy,state} RO; 4 {7'b0,ovf} W1C; 5..7 read 0, writes ignored.
REQ-021 Accesses to channel index >= CHANNELS or pixel index > BUFFER_END SHALL read 0 and ignore writes.
REQ-022 busDataOut SHALL update on the edge where busRead=1 (valid next cycle) and hold otherwise.
REQ-023 Simultaneous busRead and busWrite to the same location SHALL return the pre-write value.
REQ-024 pixData[c] SHALL present buffer[c][pixAddr[c]] one cycle after pixAddr is sampled; out-of-range index gives 0.
REQ-025 Writing ctrl with init=1 SHALL clear limit, run, loop, 32bit of that channel in the same edge and set its clear-pending bit; the other written bits are discarded.
REQ-026 A single shared clear FSM SHALL have states IDLE, CLEAR, DONE: IDLE->CLEAR when any pending bit set, selecting lowest channel; CLEAR writes 0 to one index per cycle from 0 to BUFFER_END; CLEAR->DONE after index BUFFER_END; DONE pulses initDone[c], clears pending[c] and ctrl.init[c], returns to IDLE.
REQ-027 Clear of one channel SHALL take BUFFER_END+3 cycles from pending to initDone pulse inclusive of IDLE selection.
REQ-028 init requests for other channels during CLEAR SHALL queue; re-requesting the active channel SHALL be ignored.
REQ-029 Bus buffer writes to a channel with initBusy=1 SHALL be dropped; bus reads SHALL return 0.
REQ-030 ctrl writes other than init to a busy channel SHALL be ignored.
REQ-031 run[c] SHALL follow priority: syncStart[c] sets 1 > streamSyncOf[c] loads loop[c] > bus write.
REQ-032 streamSyncOf[c] while run[c]=0 SHALL set sticky ovf[c]; writing 1 to bit0 of reg 4 clears it, set wins over simultaneous clear.
REQ-033 Controls SHALL be writable while streaming; limit and 32bit changes are software's responsibility to time.

Reset
REQ-034 On busReset all ctrl bits, regMax, ovf, pending, busDataOut SHALL be 0, FSM IDLE, initDone 0, asynchronously.
REQ-035 Buffer contents SHALL be undefined after reset; reset mid-CLEAR SHALL abort the clear without initDone.

Verification
REQ-036 Write 0xA5 to channel 1 index 7, read back -> busDataOut=0xA5 next cycle; channel 0 index 7 unchanged; pixData[1]=0xA5 one cycle after pixAddr[1]=7.
REQ-037 BUFFER_END=15: set ctrl=0x1E then write ctrl=0x01 on channel 0 -> ctrl bits 0 same edge, initBusy[0]=1, initDone[0] pulses 18 cycles later, all 16 bytes read 0.
REQ-038 init on channels 1 then 0 during channel-1 CLEAR -> channel 1 completes first, channel 0 follows, two initDone pulses, no overlap.
REQ-039 loop=1, syncStart and streamSyncOf same cycle -> run=1; loop=0 then streamSyncOf -> run=0; second streamSyncOf -> ovf=1; W1C write -> ovf=0.
REQ-040 Assert busReset during CLEAR at index 5 -> outputs zero immediately, no initDone, FSM IDLE after release.
REQ-041 Access channel CHANNELS and register 6 -> reads 0, writes no effect on any channel.
